block_move_ctrl: RTL and testbench

//  Motion controller for the coloured block drawn by the VGA top level.

---
 rtl/block_move_ctrl.sv | 176 +++++++++++++++++
 tb/tb_block_move_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/block_move_ctrl.sv
// Block motion controller: decodes PS/2 WASD/space, paces steps from move_tick and
// commits clamped offsets on frame_end. Define WRAP_AROUND_EN to wrap at the edges instead of saturating.
module block_move_ctrl #(
    parameter int BLK_W = 100,
    parameter int BLK_H = 100,
    parameter int STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [7:0]  key_code,
    input  logic        key_valid,
    input  logic        move_tick,
    input  logic        frame_end,
    output logic [10:0] off_x,
    output logic [10:0] off_y,
    output logic        moving,
    output logic [1:0]  dir
);

    localparam logic [10:0] STEP_V  = 11'(STEP);
    localparam logic [10:0] MAX_X_0 = 11'(640 - BLK_W);
    localparam logic [10:0] MAX_X_1 = 11'(800 - BLK_W);
    localparam logic [10:0] MAX_Y_0 = 11'(480 - BLK_H);
    localparam logic [10:0] MAX_Y_1 = 11'(600 - BLK_H);

    localparam logic [7:0] KEY_BREAK = 8'hF0;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    typedef enum logic {IDLE, BREAK} state_t;

    state_t      state, state_nx;
    logic        moving_nx;
    logic [1:0]  dir_nx;
    logic        recenter_pending, recenter_nx;
    logic        step_pending, step_nx;
    logic [10:0] off_x_nx, off_y_nx;
    logic [10:0] max_x, max_y;
    logic [10:0] base_x, base_y;

    function automatic logic [7:0] dir_key(input logic [1:0] d);
        case (d)
            2'd0:    dir_key = 8'h1D;
            2'd1:    dir_key = 8'h1B;
            2'd2:    dir_key = 8'h1C;
            default: dir_key = 8'h23;
        endcase
    endfunction

    function automatic logic is_make(input logic [7:0] code);
        is_make = (code == 8'h1D) || (code == 8'h1B) || (code == 8'h1C) || (code == 8'h23);
    endfunction

    function automatic logic [1:0] make_dir(input logic [7:0] code);
        case (code)
            8'h1D:   make_dir = 2'd0;
            8'h1B:   make_dir = 2'd1;
            8'h1C:   make_dir = 2'd2;
            default: make_dir = 2'd3;
        endcase
    endfunction

    function automatic logic [10:0] clamp_max(input logic [10:0] v, input logic [10:0] mx);
        clamp_max = (v > mx) ? mx : v;
    endfunction

    // Comparisons are done before any subtraction so the 11-bit result can never wrap.
    function automatic logic [10:0] inc_off(input logic [10:0] v, input logic [10:0] mx);
`ifdef WRAP_AROUND_EN
        if (v >= mx)
            inc_off = '0;
        else if (v >= mx - STEP_V)
            inc_off = mx;
        else
            inc_off = v + STEP_V;
`else
        if (v >= mx - STEP_V)
            inc_off = mx;
        else
            inc_off = v + STEP_V;
`endif
    endfunction

    function automatic logic [10:0] dec_off(input logic [10:0] v, input logic [10:0] mx);
        if (v < STEP_V) begin
`ifdef WRAP_AROUND_EN
            dec_off = mx;
`else
            dec_off = '0;
`endif
        end else begin
            dec_off = v - STEP_V;
        end
    endfunction

    assign max_x = mode ? MAX_X_1 : MAX_X_0;
    assign max_y = mode ? MAX_Y_1 : MAX_Y_0;

    always_comb begin
        state_nx    = state;
        moving_nx   = moving;
        dir_nx      = dir;
        recenter_nx = recenter_pending;
        step_nx     = step_pending;
        off_x_nx    = off_x;
        off_y_nx    = off_y;
        base_x      = clamp_max(off_x, max_x);
        base_y      = clamp_max(off_y, max_y);

        if (key_valid) begin
            case (state)
                IDLE: begin
                    if (key_code == KEY_BREAK) begin
                        state_nx = BREAK;
                    end else if (is_make(key_code)) begin
                        dir_nx    = make_dir(key_code);
                        moving_nx = 1'b1;
                    end else if (key_code == KEY_SPACE) begin
                        recenter_nx = 1'b1;
                    end
                end
                default: begin
                    if (key_code != KEY_BREAK) begin
                        state_nx = IDLE;
                        if (key_code == dir_key(dir))
                            moving_nx = 1'b0;
                    end
                end
            endcase
        end

        // A tick counts if a key was held before this edge or is made on it.
        if (move_tick && (moving || moving_nx))
            step_nx = 1'b1;

        if (frame_end) begin
            off_x_nx = base_x;
            off_y_nx = base_y;
            if (recenter_nx) begin
                off_x_nx    = max_x >> 1;
                off_y_nx    = max_y >> 1;
                recenter_nx = 1'b0;
                step_nx     = 1'b0;
            end else if (step_nx) begin
                case (dir_nx)
                    2'd0:    off_y_nx = dec_off(base_y, max_y);
                    2'd1:    off_y_nx = inc_off(base_y, max_y);
                    2'd2:    off_x_nx = dec_off(base_x, max_x);
                    default: off_x_nx = inc_off(base_x, max_x);
                endcase
                step_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            moving           <= 1'b0;
            dir              <= 2'd0;
            recenter_pending <= 1'b0;
            step_pending     <= 1'b0;
            off_x            <= '0;
            off_y            <= '0;
        end else begin
            state            <= state_nx;
            moving           <= moving_nx;
            dir              <= dir_nx;
            recenter_pending <= recenter_nx;
            step_pending     <= step_nx;
            off_x            <= off_x_nx;
            off_y            <= off_y_nx;
        end
    end

endmodule

// File: tb/tb_block_move_ctrl.sv
// Bench for block_move_ctrl: vector table plus hand sequences, expectations queued
// when driven and checked one clock later.
module tb_block_move_ctrl;

    logic        clk = 1'b0;
    logic        rst, mode, key_valid, move_tick, frame_end;
    logic [7:0]  key_code;
    logic [10:0] off_x, off_y;
    logic        moving;
    logic [1:0]  dir;

`ifdef WRAP_AROUND_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    block_move_ctrl dut (
        .clk(clk), .rst(rst), .mode(mode), .key_code(key_code), .key_valid(key_valid),
        .move_tick(move_tick), .frame_end(frame_end),
        .off_x(off_x), .off_y(off_y), .moving(moving), .dir(dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, m, kv;
        logic [7:0]  kc;
        logic        t, f;
        logic [10:0] ex, ey;
        logic        em;
        logic [1:0]  ed;
        string       nm;
    } vec_t;

    typedef struct {
        logic [10:0] ex, ey;
        logic        em;
        logic [1:0]  ed;
        string       nm;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, m, kv, input logic [7:0] kc, input logic t, f,
                       input logic [10:0] ex, ey, input logic em, input logic [1:0] ed,
                       input string nm);
        vec_t v;
        v.r = r; v.m = m; v.kv = kv; v.kc = kc; v.t = t; v.f = f;
        v.ex = ex; v.ey = ey; v.em = em; v.ed = ed; v.nm = nm;
        vecs.push_back(v);
    endtask

    task automatic cyc(input logic r, m, kv, input logic [7:0] kc, input logic t, f,
                       input logic [10:0] ex, ey, input logic em, input logic [1:0] ed,
                       input string nm);
        exp_t e;
        rst = r; mode = m; key_valid = kv; key_code = kc; move_tick = t; frame_end = f;
        e.ex = ex; e.ey = ey; e.em = em; e.ed = ed; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0; key_valid = 1'b0; move_tick = 1'b0; frame_end = 1'b0;
        e = sb.pop_front();
        n_chk++;
        if (off_x !== e.ex || off_y !== e.ey || moving !== e.em || dir !== e.ed) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d moving=%0b dir=%0d, want x=%0d y=%0d moving=%0b dir=%0d",
                     e.nm, off_x, off_y, moving, dir, e.ex, e.ey, e.em, e.ed);
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; key_valid = 1'b0; key_code = 8'h00;
        move_tick = 1'b0; frame_end = 1'b0;

        // r m kv code  t f   x    y   mv dir
        add(1, 0, 0, 8'h00, 0, 0,  0,   0, 0, 0, "reset");
        add(0, 0, 1, 8'h23, 0, 0,  0,   0, 1, 3, "make_d");
        add(0, 0, 0, 8'h00, 1, 0,  0,   0, 1, 3, "tick_only");
        add(0, 0, 0, 8'h00, 0, 1,  4,   0, 1, 3, "step1");
        add(0, 0, 0, 8'h00, 1, 1,  8,   0, 1, 3, "step2_same_cycle");
        add(0, 0, 0, 8'h00, 1, 0,  8,   0, 1, 3, "tick3");
        add(0, 0, 0, 8'h00, 0, 1, 12,   0, 1, 3, "step3");
        add(0, 0, 1, 8'hF0, 0, 0, 12,   0, 1, 3, "break_prefix");
        add(0, 0, 1, 8'h23, 0, 0, 12,   0, 0, 3, "break_d");
        add(0, 0, 0, 8'h00, 1, 0, 12,   0, 0, 3, "idle_tick");
        add(0, 0, 0, 8'h00, 0, 1, 12,   0, 0, 3, "idle_frame");
        add(0, 0, 0, 8'h00, 1, 1, 12,   0, 0, 3, "idle_tick_frame");
        add(0, 0, 1, 8'h1D, 0, 0, 12,   0, 1, 0, "make_w");
        add(0, 0, 1, 8'h1B, 0, 0, 12,   0, 1, 1, "make_s_wins");
        add(0, 0, 1, 8'hF0, 0, 0, 12,   0, 1, 1, "brk_pfx2");
        add(0, 0, 1, 8'hF0, 0, 0, 12,   0, 1, 1, "f0_in_break");
        add(0, 0, 1, 8'h23, 0, 0, 12,   0, 1, 1, "break_nonheld");
        add(0, 0, 0, 8'h00, 1, 0, 12,   0, 1, 1, "multi_tick1");
        add(0, 0, 0, 8'h00, 1, 0, 12,   0, 1, 1, "multi_tick2");
        add(0, 0, 0, 8'h00, 1, 0, 12,   0, 1, 1, "multi_tick3");
        add(0, 0, 0, 8'h00, 0, 1, 12,   4, 1, 1, "ticks_collapse");
        add(0, 0, 0, 8'h00, 0, 1, 12,   4, 1, 1, "no_new_tick");
        add(0, 0, 1, 8'hF0, 0, 0, 12,   4, 1, 1, "brk_pfx3");
        add(0, 0, 1, 8'h1B, 0, 0, 12,   4, 0, 1, "break_s");
        add(0, 0, 1, 8'h1C, 1, 0, 12,   4, 1, 2, "make_a_with_tick");
        add(0, 0, 0, 8'h00, 0, 1,  8,   4, 1, 2, "step_left");
        add(0, 0, 1, 8'hF0, 0, 0,  8,   4, 1, 2, "brk_pfx4");
        add(0, 0, 1, 8'h1C, 0, 0,  8,   4, 0, 2, "break_a");
        add(0, 0, 1, 8'h29, 0, 0,  8,   4, 0, 2, "space");
        add(0, 0, 0, 8'h00, 0, 1, 270, 190, 0, 2, "recenter_m0");
        add(0, 1, 1, 8'h29, 0, 0, 270, 190, 0, 2, "space_m1");
        add(0, 1, 0, 8'h00, 0, 1, 350, 250, 0, 2, "recenter_m1");
        add(1, 1, 1, 8'h23, 1, 1,  0,   0, 0, 0, "rst_wins");

        foreach (vecs[i])
            cyc(vecs[i].r, vecs[i].m, vecs[i].kv, vecs[i].kc, vecs[i].t, vecs[i].f,
                vecs[i].ex, vecs[i].ey, vecs[i].em, vecs[i].ed, vecs[i].nm);

        // Walk right to the mode-0 edge from the centre.
        cyc(0, 0, 1, 8'h29, 0, 0, 0, 0, 0, 0, "space_r");
        cyc(0, 0, 0, 8'h00, 0, 1, 270, 190, 0, 0, "center_r");
        cyc(0, 0, 1, 8'h23, 0, 0, 270, 190, 1, 3, "hold_d");
        for (int i = 0; i < 67; i++)
            cyc(0, 0, 0, 8'h00, 1, 1, 11'(274 + 4 * i), 190, 1, 3, "walk_right");
        cyc(0, 0, 0, 8'h00, 1, 1, 540, 190, 1, 3, "reach_max_x");
        cyc(0, 0, 0, 8'h00, 1, 1, WRAP ? 11'd0 : 11'd540, 190, 1, 3, "past_max_x");

        // Step left from zero.
        cyc(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, "rst_left");
        cyc(0, 0, 1, 8'h1C, 0, 0, 0, 0, 1, 2, "hold_a");
        cyc(0, 0, 0, 8'h00, 1, 1, WRAP ? 11'd540 : 11'd0, 0, 1, 2, "below_zero_x");

        // Walk to the mode-1 edge, then drop to mode 0.
        cyc(1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, "rst_m1");
        cyc(0, 1, 1, 8'h29, 1, 1, 350, 250, 0, 0, "space_same_frame");
        cyc(0, 1, 1, 8'h23, 0, 0, 350, 250, 1, 3, "hold_d_m1");
        for (int i = 0; i < 88; i++)
            cyc(0, 1, 0, 8'h00, 1, 1, (i < 87) ? 11'(354 + 4 * i) : 11'd700, 250, 1, 3, "walk_m1");
        cyc(0, 1, 1, 8'hF0, 0, 0, 700, 250, 1, 3, "brk_pfx_m1");
        cyc(0, 1, 1, 8'h23, 0, 0, 700, 250, 0, 3, "release_m1");
        cyc(0, 0, 0, 8'h00, 0, 1, 540, 250, 0, 3, "mode_switch_clamp");

        // Reset clears a half-received break.
        cyc(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, "rst_fsm");
        cyc(0, 0, 1, 8'h1B, 1, 1, 0, 4, 1, 1, "make_tick_frame");
        cyc(0, 0, 1, 8'hF0, 0, 0, 0, 4, 1, 1, "enter_break");
        cyc(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, "rst_while_moving");
        cyc(0, 0, 1, 8'h1D, 0, 0, 0, 0, 1, 0, "make_after_rst");
        cyc(0, 0, 1, 8'hF0, 0, 0, 0, 0, 1, 0, "f0_after_make");
        cyc(0, 0, 1, 8'h1D, 0, 0, 0, 0, 0, 0, "break_w");
        cyc(0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, "no_step_released");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
